// File: rtl/alu_pclk_sequencer.sv
// Power-clock sequencer for the adiabatic ALU (AND/OR/XOR arrays and ripple adder).
// Optional op_count output is enabled by defining ALU_PCLK_SEQ_OPCNT_EN.
module alu_pclk_sequencer #(
  parameter int PHASE_CYC    = 4,
  parameter int LOGIC_STAGES = 2,
  parameter int ADD_STAGES   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  output logic        req_ready,
  output logic [3:0]  unit_sel,
  output logic [1:0]  pc1_phase,
  output logic [1:0]  pc2_phase,
  output logic        cap_en,
  output logic        resp_valid,
  input  logic        resp_ready,
`ifdef ALU_PCLK_SEQ_OPCNT_EN
  output logic [15:0] op_count,
`endif
  output logic        busy
);

  localparam int SW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam int CW = $clog2(ADD_STAGES + 5);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  logic [1:0]    state;
  logic [SW-1:0] subCnt;
  logic [CW-1:0] phaseCnt;
  logic [CW-1:0] stageTarget;
  logic          tick;

  assign tick       = (subCnt == SW'(PHASE_CYC - 1));
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == HOLD);

  // The ramp entered at accept counts as the first phase, so HOLD is reached
  // on the tick where the count already equals the target, without advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      subCnt      <= '0;
      phaseCnt    <= '0;
      stageTarget <= '0;
      unit_sel    <= 4'b0000;
      pc1_phase   <= 2'd3;
      pc2_phase   <= 2'd3;
      cap_en      <= 1'b0;
`ifdef ALU_PCLK_SEQ_OPCNT_EN
      op_count    <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          cap_en <= 1'b0;
          if (req_valid) begin
            stageTarget <= (req_op == 2'd3) ? CW'(ADD_STAGES) : CW'(LOGIC_STAGES);
            unit_sel    <= 4'b0001 << req_op;
            pc1_phase   <= 2'd0;
            pc2_phase   <= 2'd3;
            subCnt      <= '0;
            phaseCnt    <= CW'(1);
            state       <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            subCnt <= '0;
            if (phaseCnt == stageTarget) begin
              state  <= HOLD;
              cap_en <= 1'b1;
            end else begin
              pc1_phase <= pc1_phase + 2'd1;
              pc2_phase <= pc1_phase;
              phaseCnt  <= phaseCnt + CW'(1);
            end
          end else begin
            subCnt <= subCnt + SW'(1);
          end
        end
        HOLD: begin
          cap_en <= 1'b0;
          if (resp_ready) begin
            state  <= RECOVER;
            subCnt <= '0;
`ifdef ALU_PCLK_SEQ_OPCNT_EN
            op_count <= op_count + 16'h0001;
`endif
          end
        end
        default: begin
          // pc1 parks at idle; pc2 follows it, so both are idle once pc1 was idle.
          if (tick) begin
            subCnt    <= '0;
            pc1_phase <= (pc1_phase == 2'd3) ? 2'd3 : pc1_phase + 2'd1;
            pc2_phase <= pc1_phase;
            if (pc1_phase == 2'd3) begin
              state    <= IDLE;
              unit_sel <= 4'b0000;
              phaseCnt <= '0;
            end
          end else begin
            subCnt <= subCnt + SW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pclk_sequencer.sv
// Self-checking bench for alu_pclk_sequencer: vector table plus scoreboard queue,
// with hand-written busy-request and mid-run reset sequences.
module tb_alu_pclk_sequencer;

  logic       clk;
  logic       rst;
  logic       reqValid;
  logic [1:0] reqOp;
  logic       reqReady;
  logic [3:0] unitSel;
  logic [1:0] pc1Phase;
  logic [1:0] pc2Phase;
  logic       capEn;
  logic       respValid;
  logic       respReady;
  logic       busy;
`ifdef ALU_PCLK_SEQ_OPCNT_EN
  logic [15:0] opCount;
`endif

  int testsRun;
  int testsFailed;
  int completedOps;

  typedef struct {
    logic [1:0] op;
    int         holdWant;
    int         lat;
    logic [1:0] pc1Hold;
    logic [1:0] pc2Hold;
    int         recovPhases;
    logic [3:0] sel;
  } vec_t;

  vec_t vecs[6];
  vec_t sbQ[$];

  alu_pclk_sequencer #(
    .PHASE_CYC(4),
    .LOGIC_STAGES(2),
    .ADD_STAGES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(reqValid),
    .req_op(reqOp),
    .req_ready(reqReady),
    .unit_sel(unitSel),
    .pc1_phase(pc1Phase),
    .pc2_phase(pc2Phase),
    .cap_en(capEn),
    .resp_valid(respValid),
    .resp_ready(respReady),
`ifdef ALU_PCLK_SEQ_OPCNT_EN
    .op_count(opCount),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one request from the table and follows it through HOLD and RECOVER.
  task automatic applyStimulus(input vec_t v);
    vec_t       e;
    int         t;
    int         holdCount;
    int         capExtra;
    int         pcMoved;
    logic [1:0] p1;
    logic [1:0] p2;
    reqValid  = 1'b1;
    reqOp     = v.op;
    respReady = (v.holdWant == 1);
    sbQ.push_back(v);
    stepCycle();
    reqValid = 1'b0;
    t = 0;
    checkOutput("accept_unit_sel", 32'(unitSel), 32'(v.sel));
    checkOutput("accept_pc", 32'({pc1Phase, pc2Phase}), 32'({2'd0, 2'd3}));
    while (!respValid && t < 100) begin
      stepCycle();
      t++;
      if (t == 4) checkOutput("first_tick_pc", 32'({pc1Phase, pc2Phase}), 32'({2'd1, 2'd0}));
    end
    if (!respValid) begin
      checkOutput("resp_timeout", 0, 1);
      return;
    end
    e = sbQ.pop_front();
    checkOutput("resp_latency", 32'(t), 32'(e.lat));
    checkOutput("hold_pc", 32'({pc1Phase, pc2Phase}), 32'({e.pc1Hold, e.pc2Hold}));
    checkOutput("hold_cap_en", 32'(capEn), 1);
    checkOutput("hold_unit_sel", 32'(unitSel), 32'(e.sel));
    p1 = pc1Phase;
    p2 = pc2Phase;
    holdCount = 1;
    capExtra  = 0;
    pcMoved   = 0;
    if (e.holdWant == 1) respReady = 1'b1;
    while (respValid && holdCount < 60) begin
      if (holdCount == e.holdWant) respReady = 1'b1;
      stepCycle();
      t++;
      if (respValid) begin
        holdCount++;
        if (capEn) capExtra++;
        if (pc1Phase != p1 || pc2Phase != p2) pcMoved++;
      end
    end
    completedOps++;
    checkOutput("hold_length", 32'(holdCount), 32'(e.holdWant));
    if (e.holdWant > 1) begin
      checkOutput("hold_cap_repeat", 32'(capExtra), 0);
      checkOutput("hold_pc_frozen", 32'(pcMoved), 0);
    end
    respReady = 1'b0;
    while (!reqReady && t < 200) begin
      checkOutput("recover_unit_sel", 32'(unitSel), 32'(e.sel));
      stepCycle();
      t++;
    end
    checkOutput("idle_offset", 32'(t), 32'(e.lat + e.holdWant + e.recovPhases * 4));
    checkOutput("idle_pc", 32'({pc1Phase, pc2Phase}), 32'({2'd3, 2'd3}));
    checkOutput("idle_unit_sel", 32'(unitSel), 0);
    checkOutput("idle_busy", 32'(busy), 0);
`ifdef ALU_PCLK_SEQ_OPCNT_EN
    checkOutput("op_count", 32'(opCount), 32'(completedOps));
`endif
  endtask

  initial begin
    int t;
    int busyErr;
    testsRun     = 0;
    testsFailed  = 0;
    completedOps = 0;
    reqValid     = 1'b0;
    reqOp        = 2'd0;
    respReady    = 1'b0;
    rst          = 1'b1;

    //         op    hold lat pc1H  pc2H  recov sel
    vecs[0] = '{2'd0, 1,  8,  2'd1, 2'd0, 3,    4'b0001};
    vecs[1] = '{2'd1, 1,  8,  2'd1, 2'd0, 3,    4'b0010};
    vecs[2] = '{2'd2, 20, 8,  2'd1, 2'd0, 3,    4'b0100};
    vecs[3] = '{2'd3, 1,  32, 2'd3, 2'd2, 1,    4'b1000};
    vecs[4] = '{2'd3, 3,  32, 2'd3, 2'd2, 1,    4'b1000};
    vecs[5] = '{2'd0, 2,  8,  2'd1, 2'd0, 3,    4'b0001};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    stepCycle();
    checkOutput("reset_req_ready", 32'(reqReady), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_pc", 32'({pc1Phase, pc2Phase}), 32'({2'd3, 2'd3}));
    checkOutput("reset_unit_sel", 32'(unitSel), 0);
    checkOutput("reset_resp_valid", 32'(respValid), 0);
    checkOutput("reset_cap_en", 32'(capEn), 0);
`ifdef ALU_PCLK_SEQ_OPCNT_EN
    checkOutput("reset_op_count", 32'(opCount), 0);
`endif

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      stepCycle();
    end

    // OR held on req_valid throughout an AND must wait for the first IDLE edge.
    reqValid  = 1'b1;
    reqOp     = 2'd0;
    respReady = 1'b1;
    stepCycle();
    reqOp   = 2'd1;
    t       = 0;
    busyErr = 0;
    while (!reqReady && t < 100) begin
      if (unitSel != 4'b0001) busyErr++;
      stepCycle();
      t++;
    end
    checkOutput("busy_req_ignored", 32'(busyErr), 0);
    checkOutput("busy_idle_offset", 32'(t), 21);
    stepCycle();
    reqValid = 1'b0;
    completedOps++;
    checkOutput("busy_or_accepted", 32'(unitSel), 32'(4'b0010));
    checkOutput("busy_or_running", 32'(reqReady), 0);
    t = 0;
    while (!reqReady && t < 100) begin
      stepCycle();
      t++;
    end
    checkOutput("busy_or_done", 32'(t), 21);
    completedOps++;
    respReady = 1'b0;
`ifdef ALU_PCLK_SEQ_OPCNT_EN
    checkOutput("busy_op_count", 32'(opCount), 32'(completedOps));
`endif

    // Asynchronous reset in the middle of an ADD.
    stepCycle();
    reqValid = 1'b1;
    reqOp    = 2'd3;
    stepCycle();
    reqValid = 1'b0;
    repeat (5) stepCycle();
    checkOutput("pre_reset_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset_pc", 32'({pc1Phase, pc2Phase}), 32'({2'd3, 2'd3}));
    checkOutput("midrun_reset_unit_sel", 32'(unitSel), 0);
    checkOutput("midrun_reset_busy", 32'(busy), 0);
    checkOutput("midrun_reset_req_ready", 32'(reqReady), 1);
    completedOps = 0;
`ifdef ALU_PCLK_SEQ_OPCNT_EN
    checkOutput("midrun_reset_op_count", 32'(opCount), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    stepCycle();
    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
